// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code consumer: pops bytes from the keyboard receiver FIFO,
// decodes make / break (F0) / extended (E0) sequences and tracks the held key.
module ps2_key_ctrl #(
  parameter int GAP_CYCLES = 2,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ready,
  input  logic [7:0]         data,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_valid,
  output logic               new_key,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_seen
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_valid_q, key_valid_d;
  logic               new_key_q, new_key_d;
  logic [COUNT_W-1:0] press_count_q, press_count_d;
  logic               ovf_seen_q, ovf_seen_d;
  logic               brk_pend_q, brk_pend_d;
  logic               ext_pend_q, ext_pend_d;
  logic               match;

  // Incoming byte refers to the key currently being tracked (same code and prefix).
  assign match = key_valid_q && (data == key_code_q) && (ext_pend_q == key_ext_q);

  // Next-state logic: handshake sequencing plus scan-code decode on each captured byte.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_valid_d   = key_valid_q;
    new_key_d     = 1'b0;
    press_count_d = press_count_q;
    ovf_seen_d    = ovf_seen_q | overflow;
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;

    case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = POP;
          if (data == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (data == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
            if (brk_pend_q) begin
              // Release: only a release of the tracked key drops key_valid.
              if (match) key_valid_d = 1'b0;
            end else if (!match) begin
              // Fresh make; a matching make is typematic repeat and is ignored.
              key_code_d    = data;
              key_ext_d     = ext_pend_q;
              key_valid_d   = 1'b1;
              new_key_d     = 1'b1;
              press_count_d = press_count_q + COUNT_W'(1);
            end
          end
        end
      end
      POP: begin
        state_d = GAP;
        cnt_d   = 4'd0;
      end
      GAP: begin
        // Hold off so the receiver's pointer and ready flag settle after the pop.
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Registered pop strobe: low exactly while the FSM sits in POP.
    nextdata_n_d = (state_d != POP);
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      nextdata_n_q  <= 1'b1;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_valid_q   <= 1'b0;
      new_key_q     <= 1'b0;
      press_count_q <= '0;
      ovf_seen_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      nextdata_n_q  <= nextdata_n_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_valid_q   <= key_valid_d;
      new_key_q     <= new_key_d;
      press_count_q <= press_count_d;
      ovf_seen_q    <= ovf_seen_d;
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_valid   = key_valid_q;
  assign new_key     = new_key_q;
  assign press_count = press_count_q;
  assign ovf_seen    = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a receiver FIFO model feeds bytes,
// expected makes are queued at stimulus time and checked by a monitor.
module tb_ps2_key_ctrl;

  localparam int GAP_CYCLES = 2;
  localparam int COUNT_W    = 8;
  localparam int SPACING    = 2 + GAP_CYCLES;

  logic               clk = 1'b0;
  logic               clr = 1'b1;
  logic               ready = 1'b0;
  logic [7:0]         data = 8'h00;
  logic               overflow = 1'b0;
  logic               nextdata_n;
  logic [7:0]         key_code;
  logic               key_ext;
  logic               key_valid;
  logic               new_key;
  logic [COUNT_W-1:0] press_count;
  logic               ovf_seen;

  ps2_key_ctrl #(.GAP_CYCLES(GAP_CYCLES), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_valid(key_valid), .new_key(new_key), .press_count(press_count),
    .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic [7:0] cnt;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  rxq[$];
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_start = -1;
  bit          rst_seen = 0;
  bit          prev_low = 0;
  bit          prev_nk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic expect_make(input logic [7:0] code, input logic ext, input logic [7:0] cnt);
    exp_t e;
    e.code = code; e.ext = ext; e.cnt = cnt;
    expq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (rxq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rxq.size() != 0) check("drain_timeout", 32'(rxq.size()), 0);
    repeat (SPACING + 4) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_nextdata_n"}, nextdata_n, 1);
    check({tag, "_key_code"}, key_code, 0);
    check({tag, "_key_ext"}, key_ext, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_new_key"}, new_key, 0);
    check({tag, "_press_count"}, press_count, 0);
    check({tag, "_ovf_seen"}, ovf_seen, 0);
  endtask

  task automatic do_reset(input string tag);
    rxq.delete();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_reset(tag);
    clr = 1'b0;
    pulses = 0;
  endtask

  // Receiver FIFO model: pops on the low nextdata_n cycle, presents head byte.
  always @(negedge clk) begin
    if (nextdata_n == 1'b0 && rxq.size() > 0) void'(rxq.pop_front());
    ready = (rxq.size() != 0);
    data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  always @(posedge clk) begin
    cyc++;
    if (clr) rst_seen = 1;
  end

  // Scoreboard monitor: every new_key pulse must match the oldest expected make.
  always @(negedge clk) begin
    if (new_key === 1'b1) begin
      if (prev_nk) check("new_key_width", 2, 1);
      check("new_key_with_pop", nextdata_n, 0);
      if (expq.size() == 0) begin
        check("unexpected_new_key", {24'h0, key_code}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        $display("make code=%02h ext=%0d count=%0d (exp %02h %0d %0d)",
                 key_code, key_ext, press_count, e.code, e.ext, e.cnt);
        check("make_code", key_code, e.code);
        check("make_ext", key_ext, e.ext);
        check("make_count", press_count, e.cnt);
      end
    end
    prev_nk = (new_key === 1'b1);
  end

  // Pop-pulse monitor: one cycle wide, spaced at least 2+GAP_CYCLES apart.
  always @(negedge clk) begin
    if (rst_seen) begin
      last_start = -1;
      rst_seen   = 0;
    end
    if (nextdata_n === 1'b0) begin
      if (prev_low) check("pop_width", 2, 1);
      else begin
        pulses++;
        if (last_start >= 0 && (cyc - last_start) < SPACING)
          check("pop_spacing", 32'(cyc - last_start), SPACING);
        last_start = cyc;
      end
    end
    prev_low = (nextdata_n === 1'b0);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");
    clr = 1'b0;

    // Single make, then its break
    do_reset("t1");
    send(8'h1C); expect_make(8'h1C, 1'b0, 8'd1);
    drain();
    check("t1_valid", key_valid, 1);
    check("t1_code", key_code, 8'h1C);
    check("t1_ext", key_ext, 0);
    check("t1_count", press_count, 1);
    check("t1_pulses", pulses, 1);
    send(8'hF0); send(8'h1C);
    drain();
    check("t2_valid", key_valid, 0);
    check("t2_count", press_count, 1);
    check("t2_pulses", pulses, 3);

    // Typematic repeats and release of an untracked key
    do_reset("t3");
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h32);
    expect_make(8'h1C, 1'b0, 8'd1);
    drain();
    check("t3_valid", key_valid, 1);
    check("t3_code", key_code, 8'h1C);
    check("t3_count", press_count, 1);
    check("t3_pulses", pulses, 5);

    // Extended sequences and the F0-E0 / E0-E0 boundaries
    do_reset("t4");
    send(8'hE0); send(8'h75); expect_make(8'h75, 1'b1, 8'd1);
    drain();
    check("t4_ext", key_ext, 1);
    check("t4_code", key_code, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    check("t4_brk_valid", key_valid, 0);
    send(8'h75); expect_make(8'h75, 1'b0, 8'd2);
    drain();
    check("t4_plain_ext", key_ext, 0);
    check("t4_plain_count", press_count, 2);
    send(8'hF0); send(8'hE0); send(8'h75);
    drain();
    check("t4_extbrk_mismatch_valid", key_valid, 1);
    send(8'hE0); send(8'hE0); send(8'h75); expect_make(8'h75, 1'b1, 8'd3);
    drain();
    check("t4_e0e0_ext", key_ext, 1);
    send(8'hF0); send(8'hE0); send(8'h75);
    drain();
    check("t4_f0e0_valid", key_valid, 0);
    check("t4_final_count", press_count, 3);

    // Counter wrap over 256 alternating makes, overflow pulse mid-stream
    do_reset("t5");
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = (i % 2 == 0) ? 8'h1C : 8'h32;
      send(c);
      expect_make(c, 1'b0, 8'((i + 1) % 256));
    end
    repeat (200) @(negedge clk);
    check("t5_ovf_before", ovf_seen, 0);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    drain();
    check("t5_count_wrap", press_count, 0);
    check("t5_code", key_code, 8'h32);
    check("t5_ovf_sticky", ovf_seen, 1);
    check("t5_pulses", pulses, 256);
    do_reset("t5_clr");

    // Reset during POP and during GAP with ready held high
    send(8'h1C); send(8'h32); send(8'h4A);
    expect_make(8'h1C, 1'b0, 8'd1);
    begin
      int n = 0;
      while (nextdata_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      if (nextdata_n !== 1'b0) check("t6_pop_timeout", 1, 0);
    end
    clr = 1'b1;
    @(negedge clk);
    check_reset("t6_pop");
    clr = 1'b0;
    expect_make(8'h32, 1'b0, 8'd1);
    begin
      int n = 0;
      @(negedge clk);
      while (nextdata_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      if (nextdata_n !== 1'b0) check("t6_pop2_timeout", 1, 0);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_reset("t6_gap");
    clr = 1'b0;
    pulses = 0;
    expect_make(8'h4A, 1'b0, 8'd1);
    drain();
    check("t6_code", key_code, 8'h4A);
    check("t6_count", press_count, 1);
    check("t6_valid", key_valid, 1);
    check("t6_pulses", pulses, 1);

    check("scoreboard_empty", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
